// File: rtl/cam_pipelined_ternary_if.sv
// Write and lookup port bundle for the pipelined ternary CAM.
// The master drives requests, and the slave (the CAM) returns BUSY and lookup results.
interface cam_pipelined_ternary_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          WE;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DIN_MASK;
  logic          WR_VALID;
  logic          BUSY;
  logic          CMP_REQ;
  logic [DW-1:0] CMP_DIN;
  logic          MATCH_VLD;
  logic          MATCH;
  logic          MULTI_MATCH;
  logic [AW-1:0] MATCH_ADDR;

  // Handshake: WE is taken only in a cycle where BUSY=0, and it is dropped silently otherwise.
  // CMP_REQ has no back-pressure. Each accepted request yields one MATCH_VLD pulse two cycles later.
  modport master (
    output WE, WR_ADDR, DIN, DIN_MASK, WR_VALID, CMP_REQ, CMP_DIN,
    input  BUSY, MATCH_VLD, MATCH, MULTI_MATCH, MATCH_ADDR
  );

  modport slave (
    input  WE, WR_ADDR, DIN, DIN_MASK, WR_VALID, CMP_REQ, CMP_DIN,
    output BUSY, MATCH_VLD, MATCH, MULTI_MATCH, MATCH_ADDR
  );
endinterface

// File: rtl/cam_pipelined_ternary.sv
// Parametrised ternary CAM. It has multi-cycle entry writes and a 2-stage lookup
// (hit vector, then priority encode) that can run in parallel with writes.
module cam_pipelined_ternary #(
  parameter int C_TCAM_ADDR_WIDTH = 5,
  parameter int C_TCAM_DATA_WIDTH = 32,
  parameter int C_TERNARY         = 1,
  parameter int C_WR_CYCLES       = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  cam_pipelined_ternary_if.slave   s_cam,
  output logic                     o_dbg_state
);

  localparam int AW    = C_TCAM_ADDR_WIDTH;
  localparam int DW    = C_TCAM_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (C_WR_CYCLES > 1) ? $clog2(C_WR_CYCLES) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_cnt_zero;
  logic          w_busy;
  logic          w_accept;
  logic          w_commit;

  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_wr_mask;
  logic          r_wr_valid;

  logic [DW-1:0]    r_data [DEPTH];
  logic [DW-1:0]    r_mask [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic [DEPTH-1:0] w_hit;
  logic             r_s1_vld;
  logic [DEPTH-1:0] r_s1_hit;

  logic             w_any;
  logic             w_multi;
  logic [AW-1:0]    w_enc_addr;
  logic             r_match_vld;
  logic             r_match;
  logic             r_multi;
  logic [AW-1:0]    r_match_addr;

  logic             w_we;
  logic             w_cmp_req;
  logic [DW-1:0]    w_cmp_din;

  assign w_we      = s_cam.WE;
  assign w_cmp_req = s_cam.CMP_REQ;
  assign w_cmp_din = s_cam.CMP_DIN;

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_cnt_zero = (r_cnt == '0);

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_we)       w_state_nxt = S_WRITE;
      S_WRITE: if (w_cnt_zero) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    w_busy   = 1'b0;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = w_we;
      S_WRITE: begin
        w_busy   = 1'b1;
        w_commit = w_cnt_zero;
      end
      default: ;
    endcase
  end

  // The counter is loaded with N-1, so BUSY covers exactly N cycles and commit lands on the last one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt      <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
      r_wr_valid <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= CW'(C_WR_CYCLES - 1);
      r_wr_addr  <= s_cam.WR_ADDR;
      r_wr_data  <= s_cam.DIN;
      r_wr_mask  <= s_cam.DIN_MASK;
      r_wr_valid <= s_cam.WR_VALID;
    end else if (w_busy && !w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Data and mask storage has no reset. An invalidate leaves it untouched.
  always_ff @(posedge CLK) begin
    if (w_commit && r_wr_valid) begin
      r_data[r_wr_addr] <= r_wr_data;
      r_mask[r_wr_addr] <= r_wr_mask;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         r_valid <= '0;
    else if (w_commit) r_valid[r_wr_addr] <= r_wr_valid;
  end

  // ---------------- match array ----------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    logic [DW-1:0] w_care;
    if (C_TERNARY != 0) begin : g_tern
      assign w_care = ~r_mask[g];
    end else begin : g_bin
      assign w_care = '1;
    end
    assign w_hit[g] = r_valid[g] && (((r_data[g] ^ w_cmp_din) & w_care) == '0);
  end

  // Stage 1 samples the pre-edge storage, so a lookup sampled at the commit edge sees the old entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_vld <= 1'b0;
      r_s1_hit <= '0;
    end else begin
      r_s1_vld <= w_cmp_req;
      if (w_cmp_req) r_s1_hit <= w_hit;
    end
  end

  // ---------------- stage 2: priority encode ----------------
  always_comb begin
    w_enc_addr = '0;
    w_any      = |r_s1_hit;
    w_multi    = |(r_s1_hit & (r_s1_hit - DEPTH'(1)));
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) w_enc_addr = AW'(i);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_match_vld  <= 1'b0;
      r_match      <= 1'b0;
      r_multi      <= 1'b0;
      r_match_addr <= '0;
    end else begin
      r_match_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_match      <= w_any;
        r_multi      <= w_multi;
        r_match_addr <= w_enc_addr;
      end
    end
  end

  assign s_cam.BUSY        = w_busy;
  assign s_cam.MATCH_VLD   = r_match_vld;
  assign s_cam.MATCH       = r_match;
  assign s_cam.MULTI_MATCH = r_multi;
  assign s_cam.MATCH_ADDR  = r_match_addr;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/cam_pipelined_ternary.md
Name: cam_pipelined_ternary

Overview:
Parametrised next-generation CAM for lookup tables in the output-port and MAC-learning paths. It generalises the fixed binary CAM in four ways: configurable depth, optional ternary (masked) entries, per-entry valid bits with invalidate, and a pipelined lookup with a valid strobe and a multi-match flag. Writes are multi-cycle, emulating SRL-based programming, and are flagged by BUSY. Lookups proceed in parallel with writes.

Parameters:
C_TCAM_ADDR_WIDTH, 5, log2 of entry count; depth = 2**C_TCAM_ADDR_WIDTH.
C_TCAM_DATA_WIDTH, 32, key/entry width in bits.
C_TERNARY, 1, 1 = per-entry mask honoured; 0 = binary CAM, DIN_MASK ignored and treated as all-zero.
C_WR_CYCLES, 16, BUSY duration per write; legal range 1..256.

Ports:
CLK  in  1  clock; all logic rising-edge.
RESET  in  1  asynchronous, active-high reset.
WE  in  1  write/invalidate request; sampled only when BUSY=0.
WR_ADDR  in  C_TCAM_ADDR_WIDTH  target entry.
DIN  in  C_TCAM_DATA_WIDTH  entry data.
DIN_MASK  in  C_TCAM_DATA_WIDTH  entry mask; bit=1 means don't-care.
WR_VALID  in  1  1 = program entry and set valid; 0 = clear valid (invalidate).
BUSY  out  1  write in progress.
CMP_REQ  in  1  lookup request, accepted every cycle.
CMP_DIN  in  C_TCAM_DATA_WIDTH  lookup key.
MATCH_VLD  out  1  lookup result strobe.
MATCH  out  1  at least one valid entry matched.
MULTI_MATCH  out  1  two or more valid entries matched.
MATCH_ADDR  out  C_TCAM_ADDR_WIDTH  lowest matching address; 0 when MATCH=0.

Behaviour:
- Reset (async assert, sync release): all valid bits=0; BUSY, MATCH_VLD, MATCH, MULTI_MATCH=0; MATCH_ADDR=0; write counter=0; any in-progress write is aborted and no entry changes. Data/mask storage is not cleared.
- Write FSM has two states, IDLE and WRITE.
  - IDLE: when WE=1 at edge t0, latch WR_ADDR, DIN, DIN_MASK and WR_VALID; load counter = C_WR_CYCLES-1; go to WRITE. BUSY=1 in cycles t0+1 .. t0+C_WR_CYCLES.
  - WRITE: decrement the counter each edge. At the edge ending the last BUSY cycle, commit the latched entry (data, mask, valid) atomically, then return to IDLE.
  - WE asserted while BUSY=1 is ignored. There is no queuing and no error flag.
  - A WE sampled in the same cycle BUSY falls is accepted (back-to-back writes).
  - Invalidate (WR_VALID=0) only clears the valid bit; data and mask are unchanged.
- Match function: entry i hits when valid[i] AND ((data[i] XOR CMP_DIN) AND NOT mask[i]) == 0. When C_TERNARY=0, the mask is forced to 0.
- Lookup pipeline, 2-cycle latency:
  - Stage 1, at the edge sampling CMP_REQ=1: register the per-entry hit vector using the storage contents as they were before that edge.
  - Stage 2: priority encode the hit vector (lowest index wins), compute MATCH and MULTI_MATCH, and register all results together with MATCH_VLD=1.
  - Results therefore appear in the second cycle after CMP_REQ. One result is produced per request; back-to-back requests yield back-to-back results.
- When CMP_REQ=0, MATCH_VLD=0 two cycles later. MATCH, MULTI_MATCH and MATCH_ADDR hold their last values while MATCH_VLD=0.
- Write/lookup collision: a lookup sampled at the commit edge sees the old entry. A lookup sampled at any later edge sees the new entry.
- All-masked ternary entry (mask all-ones) matches every key while valid.

Test Plan:
- Reset, then CMP_DIN=0x00000000 with CMP_REQ=1 -> 2 cycles later MATCH_VLD=1, MATCH=0, MULTI_MATCH=0, MATCH_ADDR=0.
- Write addr 3 = 0xDEADBEEF (mask 0, valid); check BUSY high exactly 16 cycles; lookup 0xDEADBEEF -> MATCH=1, MATCH_ADDR=3, MULTI_MATCH=0.
- Write addr 7 = 0x0A000000 with mask 0x00FFFFFF and addr 2 = 0x0A010203 with mask 0; lookup 0x0A010203 -> MATCH=1, MULTI_MATCH=1, MATCH_ADDR=2. Lookup 0x0A990000 -> MATCH_ADDR=7, MULTI_MATCH=0.
- Invalidate addr 3, then lookup 0xDEADBEEF -> MATCH=0. Issue WE during BUSY with addr 5 -> entry 5 is not written, and a lookup of its data misses.
- Lookup issued at the commit edge of a write to addr 1 -> old result. Lookup issued one cycle later -> new result. Back-to-back CMP_REQ for 4 cycles -> 4 consecutive MATCH_VLD pulses in order.
- Assert RESET mid-write (counter=8) -> BUSY=0 immediately, target entry unchanged, all entries invalid. Repeat with C_TERNARY=0, C_TCAM_ADDR_WIDTH=6, C_WR_CYCLES=1 -> mask ignored and BUSY is a 1-cycle pulse.
